hazard_ctrl: RTL

//  Consumer side of the decode-stage load-use stall request. Turns stall_i,
//  EX-stage redirects and data-memory wait into per-stage enable/flush strobes
//  for PC, IF/ID, ID/EX and EX/MEM. Also runs the post-redirect flush shadow,
//  a memory-wait timeout, and stall/flush performance counters.

---
 rtl/hazard_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Consumer side of the decode-stage load-use stall request. Converts the
//   stall request, EX-stage redirects and data-memory wait into per-stage
//   enable/flush strobes for PC, IF/ID, ID/EX and EX/MEM. Also runs the
//   post-redirect flush shadow, a memory-wait timeout, and stall/flush
//   performance counters.
//
//   Strobes are Mealy outputs: decided from the current state and this
//   cycle's inputs, with no added latency.
//
// Parameters
//   BRANCH_PENALTY  extra cycles IF/ID is flushed after a redirect (0..3)
//   MEM_TIMEOUT     consecutive busy cycles before mem_timeout_o sets (1..255)
//   CNT_W           performance counter width
//
// Ports
//   clk_i          in   core clock, rising edge
//   rst_n_i        in   asynchronous active-low reset
//   stall_i        in   load-use stall request from decode
//   redirect_i     in   EX redirect (taken branch / jump)
//   mem_busy_i     in   data memory not ready, MEM stage must hold
//   pc_en_o        out  PC load enable
//   if_id_en_o     out  IF/ID load enable
//   if_id_flush_o  out  IF/ID load NOP (wins over enable at the register)
//   id_ex_en_o     out  ID/EX load enable
//   id_ex_flush_o  out  ID/EX load bubble
//   ex_mem_en_o    out  EX/MEM load enable
//   mem_timeout_o  out  sticky memory-wait timeout flag
//   stall_cnt_o    out  cycles lost to load-use stall or memory wait
//   flush_cnt_o    out  redirects accepted
//
// State table
//   state        | meaning
//   ST_RUN       | normal flow
//   ST_FLUSH     | post-redirect shadow, IF/ID holds wrong-path fetches
//   ST_MEM_WAIT  | pipeline frozen on data memory; resume_flush_q remembers
//                | whether to return to ST_FLUSH or ST_RUN on release
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int BRANCH_PENALTY = 1,
    parameter int MEM_TIMEOUT    = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic             mem_busy_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_en_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_en_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0]       SHADOW_LOAD = 2'(BRANCH_PENALTY);
    localparam logic [7:0]       TIMEOUT_VAL = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic             resume_flush_q, resume_flush_d;
    logic [1:0]       shadow_q, shadow_d;
    logic [7:0]       wait_q;
    logic [7:0]       wait_inc;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             stall_inc, flush_inc;
    logic             in_flush;

    // Effective shadow status: a release from MEM_WAIT behaves exactly like
    // the state that was frozen, so the release cycle itself is not lost.
    assign in_flush = (state_q == ST_FLUSH) ||
                      ((state_q == ST_MEM_WAIT) && resume_flush_q);

    always_comb begin
        state_d        = state_q;
        resume_flush_d = resume_flush_q;
        shadow_d       = shadow_q;
        pc_en_o        = 1'b0;
        if_id_en_o     = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_en_o     = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_en_o    = 1'b0;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;

        if (!rst_n_i) begin
            // Hold NOPs in the front registers while reset is asserted.
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (mem_busy_i) begin
            // Full freeze: nothing advances, redirect/stall must be re-presented.
            state_d   = ST_MEM_WAIT;
            stall_inc = 1'b1;
            if (state_q != ST_MEM_WAIT) begin
                resume_flush_d = (state_q == ST_FLUSH);
            end
        end else if (redirect_i) begin
            pc_en_o       = 1'b1;
            if_id_en_o    = 1'b1;
            if_id_flush_o = 1'b1;
            id_ex_en_o    = 1'b1;
            id_ex_flush_o = 1'b1;
            ex_mem_en_o   = 1'b1;
            flush_inc     = 1'b1;
            shadow_d      = SHADOW_LOAD;
            state_d       = (SHADOW_LOAD == 2'd0) ? ST_RUN : ST_FLUSH;
        end else begin
            if (in_flush) begin
                shadow_d = shadow_q - 2'd1;
                state_d  = (shadow_q <= 2'd1) ? ST_RUN : ST_FLUSH;
            end else begin
                state_d = ST_RUN;
            end

            if (stall_i) begin
                id_ex_en_o    = 1'b1;
                id_ex_flush_o = 1'b1;
                ex_mem_en_o   = 1'b1;
                stall_inc     = 1'b1;
            end else begin
                pc_en_o       = 1'b1;
                if_id_en_o    = 1'b1;
                if_id_flush_o = in_flush;
                id_ex_en_o    = 1'b1;
                ex_mem_en_o   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= ST_RUN;
            resume_flush_q <= 1'b0;
            shadow_q       <= 2'd0;
        end else begin
            state_q        <= state_d;
            resume_flush_q <= resume_flush_d;
            shadow_q       <= shadow_d;
        end
    end

    // Wait counter saturates so a very long wait cannot wrap back under the
    // threshold; the timeout flag is sticky until reset.
    assign wait_inc = (wait_q == 8'hFF) ? wait_q : (wait_q + 8'd1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else if (mem_busy_i) begin
            wait_q <= wait_inc;
            if (wait_inc >= TIMEOUT_VAL) begin
                timeout_q <= 1'b1;
            end
        end else begin
            wait_q <= 8'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (flush_inc) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    assign mem_timeout_o = timeout_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule
